// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the memory bus arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int GNT_M0 = 0;
  localparam int GNT_M1 = 1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_if : native valid/ready memory bus (picorv32 style)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  valid;
  logic                  instr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2 : combinational 2-way round-robin selector, one-hot pick
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  // On a tie the master that was not served last wins.
  always_comb begin
    pick_o = 2'b00;
    if (req_i[GNT_M0] && (!req_i[GNT_M1] || last_i)) begin
      pick_o[GNT_M0] = 1'b1;
    end else if (req_i[GNT_M1]) begin
      pick_o[GNT_M1] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter : two-master round-robin arbiter onto one memory slave;
// optional slave watchdog enabled by MEM_ARB_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  mem_bus_if.slave    m0,
  mem_bus_if.slave    m1,
  mem_bus_if.master   s,
  output logic [1:0]  grant,
  output logic        err
);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic       last_q;

  logic [1:0] req;
  logic [1:0] pick;
  logic       busy;
  logic       sel_m1;
  logic       gnt_valid;
  logic       done;
  logic       tmo;

  assign req    = {m1.valid, m0.valid};
  assign busy   = (state_q == ARB_BUSY);
  assign sel_m1 = grant_q[GNT_M1];

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .pick_o (pick)
  );

  assign gnt_valid = sel_m1 ? m1.valid : m0.valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  assign tmo = busy && (cnt_q == CNT_W'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  // Slave side: only the granted master is visible, and only while BUSY.
  assign s.valid = busy && gnt_valid && !tmo;
  assign s.instr = busy ? (sel_m1 ? m1.instr : m0.instr) : 1'b0;
  assign s.addr  = busy ? (sel_m1 ? m1.addr  : m0.addr)  : '0;
  assign s.wdata = busy ? (sel_m1 ? m1.wdata : m0.wdata) : '0;
  assign s.wstrb = busy ? (sel_m1 ? m1.wstrb : m0.wstrb) : '0;

  assign done = s.valid && s.ready;

  assign m0.ready = (done || tmo) && !sel_m1;
  assign m1.ready = (done || tmo) &&  sel_m1;
  assign m0.rdata = tmo ? DATA_W'(TIMEOUT_RDATA) : s.rdata;
  assign m1.rdata = tmo ? DATA_W'(TIMEOUT_RDATA) : s.rdata;

  assign grant = grant_q;
  assign err   = tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|pick) begin
            grant_q <= pick;
            state_q <= ARB_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (done || tmo) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
            last_q  <= sel_m1;
          end else if (!gnt_valid) begin
            // Aborted request: release the bus without touching fairness.
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
          end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter : scoreboard bench for mem_bus_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       err;

  always #5 clk = ~clk;

  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant),
    .err   (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] rdata;
    bit          tmo;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          served[$];
  logic [1:0]  glog[$];
  logic [1:0]  gprev = 2'b00;

  int n_cmp = 0;
  int n_err = 0;

  bit          slave_en = 1'b1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  int          slave_lat = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] served_code();
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (served[i]) c = {c[27:0], 4'(served[i])};
    return c;
  endfunction

  function automatic logic [31:0] grant_code();
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (glog[i]) c = {c[27:0], 2'b00, glog[i]};
    return c;
  endfunction

  // Slave model: ready slave_lat cycles after s_valid first appears.
  initial begin : slave
    int cnt;
    cnt = 0;
    s_bus.ready = 1'b0;
    s_bus.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (s_bus.ready) begin
        s_bus.ready = 1'b0;
        cnt = 0;
      end else if (s_bus.valid && slave_en) begin
        if (cnt >= slave_lat) begin
          s_bus.ready = 1'b1;
          s_bus.rdata = use_fixed ? fixed_rdata : ~s_bus.addr;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: grant trace and scoreboard on every master ready.
  initial begin : monitor
    int   m;
    exp_t e;
    forever begin
      @(negedge clk);
      if (grant !== gprev) begin
        glog.push_back(grant);
        gprev = grant;
      end
      if (m0_bus.ready === 1'b1 || m1_bus.ready === 1'b1) begin
        m = (m1_bus.ready === 1'b1) ? 1 : 0;
        check("ready_both", 128'(m0_bus.ready & m1_bus.ready), 128'(0));
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready m%0d: got ready=1 required 0", m);
        end else begin
          if (m == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          served.push_back(m);
          check("rdata", 128'(m == 0 ? m0_bus.rdata : m1_bus.rdata), 128'(e.rdata));
          check("grant_at_ready", 128'(grant), 128'(m == 0 ? 2'b01 : 2'b10));
          check("err_at_ready", 128'(err), 128'(e.tmo));
          if (!e.tmo)
            check("slave_fields",
                  128'({s_bus.addr, s_bus.wdata, s_bus.wstrb, s_bus.instr}),
                  128'({e.addr, e.wdata, e.wstrb, e.instr}));
          else
            check("s_valid_on_timeout", 128'(s_bus.valid), 128'(0));
        end
      end else if (err !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL err_spurious: got err=%b required 0", err);
      end
    end
  end

  task automatic issue(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr,
                       input logic [31:0] exp_rdata, input bit tmo);
    exp_t e;
    int   k;
    logic got;
    e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    e.instr = instr; e.rdata = exp_rdata; e.tmo = tmo;
    if (m == 0) begin
      q0.push_back(e);
      m0_bus.addr = addr; m0_bus.wdata = wdata; m0_bus.wstrb = wstrb;
      m0_bus.instr = instr; m0_bus.valid = 1'b1;
    end else begin
      q1.push_back(e);
      m1_bus.addr = addr; m1_bus.wdata = wdata; m1_bus.wstrb = wstrb;
      m1_bus.instr = instr; m1_bus.valid = 1'b1;
    end
    k = 0;
    got = 1'b0;
    forever begin
      @(negedge clk);
      got = (m == 0) ? m0_bus.ready : m1_bus.ready;
      k++;
      if (got === 1'b1 || k >= 200) break;
    end
    if (got !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_wait_m%0d: no ready after %0d cycles, required ready", m, k);
    end
    @(posedge clk); #1;
  endtask

  task automatic drop(input int m);
    if (m == 0) m0_bus.valid = 1'b0;
    else        m1_bus.valid = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int k;
    k = 0;
    while (grant !== g && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wait_grant", 128'(grant), 128'(g));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sv;
    int k;
    int bad;
    m0_bus.valid = 1'b0; m0_bus.instr = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m1_bus.valid = 1'b0; m1_bus.instr = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 128'({grant, err, s_bus.valid, m0_bus.ready, m1_bus.ready}), 128'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Single read by m0, slave ready two cycles after s_valid
    slave_lat = 2; use_fixed = 1'b1; fixed_rdata = 32'h1234_5678;
    fork
      issue(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b0);
      begin
        @(negedge clk); check("lat_s_valid_0", 128'(s_bus.valid), 128'(0));
        @(negedge clk); check("lat_s_valid_1", 128'({s_bus.valid, grant}), 128'({1'b1, 2'b01}));
        @(negedge clk); check("lat_ready_0", 128'(m0_bus.ready), 128'(0));
        @(negedge clk); check("lat_ready_1", 128'(m0_bus.ready), 128'(1));
      end
    join
    drop(0);
    @(negedge clk); check("t1_idle_grant", 128'(grant), 128'(0));
    use_fixed = 1'b0; slave_lat = 1;

    // Simultaneous request after reset: m0 then m1, one idle cycle between
    do_reset();
    served.delete(); glog.delete(); gprev = grant;
    fork
      begin issue(0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFDF, 1'b0); drop(0); end
      begin issue(1, 32'h0000_0024, 32'hAAAA_5555, 4'hF, 1'b0, 32'hFFFF_FFDB, 1'b0); drop(1); end
    join
    @(negedge clk); @(negedge clk);
    check("tie_order", 128'(served_code()), 128'(32'hFFFF_FF01));
    check("tie_grant_seq", 128'(grant_code()), 128'(32'hFFFF_1020));

    // Both continuously requesting: strict alternation
    served.delete();
    fork
      begin
        issue(0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hFFFF_FEFF, 1'b0);
        issue(0, 32'h104, 32'h0, 4'h0, 1'b0, 32'hFFFF_FEFB, 1'b0);
        issue(0, 32'h108, 32'h0, 4'h0, 1'b0, 32'hFFFF_FEF7, 1'b0);
        drop(0);
      end
      begin
        issue(1, 32'h200, 32'h11, 4'h3, 1'b0, 32'hFFFF_FDFF, 1'b0);
        issue(1, 32'h204, 32'h22, 4'hC, 1'b1, 32'hFFFF_FDFB, 1'b0);
        issue(1, 32'h208, 32'h33, 4'h1, 1'b0, 32'hFFFF_FDF7, 1'b0);
        drop(1);
      end
    join
    @(negedge clk);
    check("alternate_order", 128'(served_code()), 128'(32'hFF01_0101));

    // m1 byte write to the output port
    served.delete();
    issue(1, 32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0, 32'hEFFF_FFFF, 1'b0);
    drop(1);
    @(negedge clk);
    check("m1_write_order", 128'(served_code()), 128'(32'hFFFF_FFF1));

    // Abort: m0 drops valid mid-transaction; last stays at m1
    slave_en = 1'b0;
    m0_bus.addr = 32'h30; m0_bus.wstrb = 4'h0; m0_bus.valid = 1'b1;
    wait_grant(2'b01);
    @(posedge clk); @(posedge clk); #1 drop(0);
    @(negedge clk); check("abort_drop_cycle", 128'({s_bus.valid, grant}), 128'({1'b0, 2'b01}));
    @(negedge clk); check("abort_idle", 128'(grant), 128'(0));
    slave_en = 1'b1;
    served.delete();
    @(posedge clk); #1;
    fork
      begin issue(0, 32'h34, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFCB, 1'b0); drop(0); end
      begin issue(1, 32'h38, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFC7, 1'b0); drop(1); end
    join
    @(negedge clk);
    check("abort_last_kept", 128'(served_code()), 128'(32'hFFFF_FF01));

    // Reset while BUSY for m1, then tie goes to m0
    served.delete();
    issue(0, 32'h50, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFAF, 1'b0);
    drop(0);
    slave_en = 1'b0;
    m1_bus.addr = 32'h60; m1_bus.wstrb = 4'h0; m1_bus.valid = 1'b1;
    wait_grant(2'b10);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_busy", 128'({s_bus.valid, grant, m1_bus.ready}), 128'(0));
    @(posedge clk); #1 drop(1); reset = 1'b0;
    slave_en = 1'b1;
    fork
      begin issue(0, 32'h54, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFAB, 1'b0); drop(0); end
      begin issue(1, 32'h58, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFA7, 1'b0); drop(1); end
    join
    @(negedge clk);
    check("reset_then_tie", 128'(served_code()), 128'(32'hFFFF_F001));

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: slave never answers, forced completion after 8 BUSY cycles
    slave_en = 1'b0;
    sv = 0; k = 0;
    fork
      begin issue(0, 32'h70, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1); drop(0); end
      begin
        forever begin
          @(negedge clk);
          if (m0_bus.ready === 1'b1 || k >= 100) break;
          if (s_bus.valid === 1'b1) sv++;
          k++;
        end
        check("tmo_busy_cycles", 128'(sv), 128'(8));
        @(negedge clk); check("tmo_err_pulse_end", 128'(err), 128'(0));
      end
    join
    slave_en = 1'b1;
`else
    // No watchdog: BUSY holds indefinitely with err low
    slave_en = 1'b0;
    m0_bus.addr = 32'h70; m0_bus.wstrb = 4'h0; m0_bus.valid = 1'b1;
    wait_grant(2'b01);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (grant !== 2'b01 || err !== 1'b0 || m0_bus.ready !== 1'b0) bad++;
    end
    check("no_tmo_hold", 128'(bad), 128'(0));
    @(posedge clk); #1 drop(0);
    @(negedge clk); @(negedge clk);
    check("no_tmo_release", 128'(grant), 128'(0));
    slave_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("queues_empty", 128'({q0.size(), q1.size()}), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master round-robin arbiter onto the native valid/ready memory bus that feeds the on-chip SRAM and the 0x1000_0000 output-byte port. Master 0 is the picorv32 core; master 1 is a secondary requester such as a DMA or a debug/firmware loader. Exactly one master transaction is forwarded to the single slave at a time. Grant is held for the whole transaction, and the ready/rdata response is routed back to the granted master.

Parameters:
ADDR_W, 32, address width of masters and slave
DATA_W, 32, data width; wstrb width is DATA_W/8
TIMEOUT, 255, slave-response watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
m0_valid  in  1  master 0 request
m0_instr  in  1  master 0 instruction-fetch flag
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 means read
m0_ready  out  1  master 0 completion pulse
m0_rdata  out  DATA_W  master 0 read data
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for master 1
s_valid  out  1  slave request
s_instr  out  1  slave instruction flag
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_wstrb  out  DATA_W/8  slave strobes
s_ready  in  1  slave completion
s_rdata  in  DATA_W  slave read data
grant  out  2  one-hot current grant; 00 when idle
err  out  1  one-cycle timeout pulse; constant 0 without the feature

Behaviour:
- States are IDLE, BUSY. State register holds state, grant, and last (index of the last master served).
- Reset (synchronous, any cycle including mid-transaction):
  - state=IDLE, grant=00, last=1 so master 0 wins the first tie.
  - All outputs are 0 in the cycle after reset; any in-flight transaction is dropped without a ready.
- IDLE:
  - s_valid=0.
  - If any mX_valid is high at the clock edge, a winner is picked and latched into grant, and the state moves to BUSY.
  - With a single requester, that requester wins.
  - With both requesting, the master other than last wins (round-robin).
- BUSY:
  - s_valid, s_instr, s_addr, s_wdata and s_wstrb are driven combinationally from the granted master's inputs; unused slave outputs are 0.
  - Arbitration latency: s_valid first rises one cycle after mX_valid.
- Completion:
  - When s_ready=1 and s_valid=1, the granted mX_ready=1 in that same cycle (combinational).
  - Next state is IDLE, last=granted index, grant=00.
  - The non-granted mX_ready is always 0.
  - s_ready while s_valid=0 is ignored.
- Read data: mX_rdata = s_rdata for both masters; it is qualified only by mX_ready.
- Back-to-back: the minimum gap between grants is one IDLE cycle. A continuously requesting master alternates with the other requester, so neither is starved.
- Abort: if the granted master's valid drops in BUSY without s_ready, the arbiter returns to IDLE next cycle and last is not updated.
- Masters hold valid and all request fields stable until ready; the arbiter does not register request fields.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT, the arbiter forces the granted mX_ready=1 with mX_rdata=32'hDEAD_BEEF and pulses err for one cycle.
  - It then enters IDLE and updates last.
  - s_valid is 0 in that cycle.
- Undefined: no counter is built, err is tied 0, and BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_BUSY)
  - grant index constants (GNT_M0=0, GNT_M1=1)
  - TIMEOUT_RDATA=32'hDEAD_BEEF
- Sub-module rr_pick2 is natural: a combinational 2-way round-robin selector with inputs req[1:0] and last, and output one-hot pick. Top-level holds the FSM, mux and counter.

Test Plan:
- Reset released, m0 reads addr 0x0000_0010, slave ready 2 cycles after s_valid with rdata 0x1234_5678 -> s_valid rises 1 cycle after m0_valid; m0_ready pulses once with m0_rdata 0x1234_5678; m1_ready stays 0; grant returns to 00.
- m0 and m1 both valid from the same cycle after reset -> m0 served first, then m1; grant sequence 01, 00, 10.
- Both masters held continuously valid for 6 transactions -> grants strictly alternate m0, m1, m0, m1, m0, m1.
- m1 writes 0x1000_0000 with wdata 0x41 and wstrb 0001 -> s_addr/s_wdata/s_wstrb equal m1's fields; m1_ready pulses once; m0 signals unaffected.
- Reset asserted while BUSY for m1 -> next cycle s_valid=0, grant=00; after release, both masters valid -> m0 wins.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, slave never readies m0 -> after 8 BUSY cycles m0_ready=1, m0_rdata=0xDEAD_BEEF, err pulses 1 cycle; without the macro, grant stays 01 indefinitely and err stays 0.
